// File: rtl/radix_4_div_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | radix_4_div_pkg : shared digit encodings and FSM state type     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package radix_4_div_pkg;

  localparam int QUOT_NEG_2 = 0;
  localparam int QUOT_NEG_1 = 1;
  localparam int QUOT_ZERO  = 2;
  localparam int QUOT_POS_1 = 3;
  localparam int QUOT_POS_2 = 4;

  localparam logic [4:0] QUOT_ONEHOT_NEG_2 = 5'b00001 << QUOT_NEG_2;
  localparam logic [4:0] QUOT_ONEHOT_NEG_1 = 5'b00001 << QUOT_NEG_1;
  localparam logic [4:0] QUOT_ONEHOT_ZERO  = 5'b00001 << QUOT_ZERO;
  localparam logic [4:0] QUOT_ONEHOT_POS_1 = 5'b00001 << QUOT_POS_1;
  localparam logic [4:0] QUOT_ONEHOT_POS_2 = 5'b00001 << QUOT_POS_2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } iter_state_t;

  // Anything that is not a legal one-hot digit is handled as digit zero.
  function automatic logic [4:0] digit_sanitize(input logic [4:0] digit);
    return $onehot(digit) ? digit : QUOT_ONEHOT_ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix_4_otf_conv.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | radix_4_otf_conv : on-the-fly Q/QM update from one radix-4 digit |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module radix_4_otf_conv
  import radix_4_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       quot_digit,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] quot_m,
  output logic [WIDTH-1:0] quot_nxt,
  output logic [WIDTH-1:0] quot_m_nxt
);

  always_comb begin
    quot_nxt   = {quot[WIDTH-3:0], 2'b00};
    quot_m_nxt = {quot_m[WIDTH-3:0], 2'b11};
    case (quot_digit)
      QUOT_ONEHOT_POS_2: begin
        quot_nxt   = {quot[WIDTH-3:0], 2'b10};
        quot_m_nxt = {quot[WIDTH-3:0], 2'b01};
      end
      QUOT_ONEHOT_POS_1: begin
        quot_nxt   = {quot[WIDTH-3:0], 2'b01};
        quot_m_nxt = {quot[WIDTH-3:0], 2'b00};
      end
      QUOT_ONEHOT_NEG_1: begin
        quot_nxt   = {quot_m[WIDTH-3:0], 2'b11};
        quot_m_nxt = {quot_m[WIDTH-3:0], 2'b10};
      end
      QUOT_ONEHOT_NEG_2: begin
        quot_nxt   = {quot_m[WIDTH-3:0], 2'b10};
        quot_m_nxt = {quot_m[WIDTH-3:0], 2'b01};
      end
      default: begin
        quot_nxt   = {quot[WIDTH-3:0], 2'b00};
        quot_m_nxt = {quot_m[WIDTH-3:0], 2'b11};
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/radix_4_iter_v1.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | radix_4_iter_v1 : radix-4 SRT divider iteration stage           |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module radix_4_iter_v1
  import radix_4_div_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int ITN_WIDTH         = WIDTH + 4,
  parameter int QUOT_ONEHOT_WIDTH = 5,
  parameter int CNT_W             = $clog2(WIDTH / 2 + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         start_valid_i,
  output logic                         start_ready_o,
  input  logic [ITN_WIDTH-1:0]         init_rem_sum_i,
  input  logic [ITN_WIDTH-1:0]         init_rem_carry_i,
  input  logic [QUOT_ONEHOT_WIDTH-1:0] init_quot_digit_i,
  input  logic [WIDTH-1:0]             divisor_i,
  input  logic [CNT_W-1:0]             iter_num_i,
  output logic [ITN_WIDTH-1:0]         rem_sum_o,
  output logic [ITN_WIDTH-1:0]         rem_carry_o,
  output logic [WIDTH-1:0]             divisor_o,
  output logic [QUOT_ONEHOT_WIDTH-1:0] prev_quot_digit_o,
  input  logic [QUOT_ONEHOT_WIDTH-1:0] quot_digit_i,
  output logic                         finish_valid_o,
  input  logic                         finish_ready_i,
  output logic [WIDTH-1:0]             quot_o,
  output logic [ITN_WIDTH-1:0]         rem_o
);

  iter_state_t           state;
  iter_state_t           state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH-1:0]      quot;
  logic [WIDTH-1:0]      quot_m;
  logic [WIDTH-1:0]      quot_otf;
  logic [WIDTH-1:0]      quot_m_otf;
  logic [ITN_WIDTH-1:0]  div_ext;
  logic [ITN_WIDTH-1:0]  sum_sh;
  logic [ITN_WIDTH-1:0]  carry_sh;
  logic [ITN_WIDTH-1:0]  term;
  logic [ITN_WIDTH-1:0]  csa_sum;
  logic [ITN_WIDTH-1:0]  csa_carry;
  logic [ITN_WIDTH-1:0]  post_rem;
  logic [ITN_WIDTH-1:0]  post_fix;
  logic                  digit_pos;

  // Divisor aligned to the remainder's fixed point: sign, WIDTH bits, 3 guard bits.
  assign div_ext   = {1'b0, divisor_o, 3'b000};
  assign sum_sh    = rem_sum_o << 2;
  assign carry_sh  = rem_carry_o << 2;
  assign digit_pos = prev_quot_digit_o[QUOT_POS_1] | prev_quot_digit_o[QUOT_POS_2];

  always_comb begin
    term = '0;
    case (prev_quot_digit_o)
      QUOT_ONEHOT_NEG_2: term = div_ext << 1;
      QUOT_ONEHOT_NEG_1: term = div_ext;
      QUOT_ONEHOT_POS_1: term = ~div_ext;
      QUOT_ONEHOT_POS_2: term = ~(div_ext << 1);
      default:           term = '0;
    endcase
  end

  // Positive digits subtract: the +1 of the two's complement rides in the free carry LSB.
  assign csa_sum   = sum_sh ^ carry_sh ^ term;
  assign csa_carry = (((sum_sh & carry_sh) | (sum_sh & term) | (carry_sh & term)) << 1)
                   | {{(ITN_WIDTH-1){1'b0}}, digit_pos};

  assign post_rem = rem_sum_o + rem_carry_o;
  assign post_fix = post_rem + div_ext;

  radix_4_otf_conv #(
    .WIDTH(WIDTH)
  ) u_otf_conv (
    .quot_digit (prev_quot_digit_o),
    .quot       (quot),
    .quot_m     (quot_m),
    .quot_nxt   (quot_otf),
    .quot_m_nxt (quot_m_otf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_valid_i) state_nxt = (iter_num_i == '0) ? ST_POST : ST_ITER;
        ST_ITER: if (cnt == CNT_W'(1)) state_nxt = ST_POST;
        ST_POST: state_nxt = ST_DONE;
        ST_DONE: if (finish_ready_i) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start_ready_o  = (state == ST_IDLE);
    finish_valid_o = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_sum_o         <= '0;
      rem_carry_o       <= '0;
      divisor_o         <= '0;
      prev_quot_digit_o <= QUOT_ONEHOT_ZERO;
      cnt               <= '0;
      quot              <= '0;
      quot_m            <= '0;
      quot_o            <= '0;
      rem_o             <= '0;
    end else if (!flush_i) begin
      case (state)
        ST_IDLE: begin
          if (start_valid_i) begin
            rem_sum_o         <= init_rem_sum_i;
            rem_carry_o       <= init_rem_carry_i;
            divisor_o         <= divisor_i;
            prev_quot_digit_o <= digit_sanitize(init_quot_digit_i);
            cnt               <= iter_num_i;
            quot              <= '0;
            quot_m            <= '0;
          end
        end
        ST_ITER: begin
          rem_sum_o         <= csa_sum;
          rem_carry_o       <= csa_carry;
          quot              <= quot_otf;
          quot_m            <= quot_m_otf;
          prev_quot_digit_o <= digit_sanitize(quot_digit_i);
          cnt               <= cnt - CNT_W'(1);
        end
        ST_POST: begin
          if (post_rem[ITN_WIDTH-1]) begin
            rem_o  <= post_fix;
            quot_o <= quot_m;
          end else begin
            rem_o  <= post_rem;
            quot_o <= quot;
          end
        end
        default: ;
      endcase
    end
  end

  // QDS must return a legal one-hot digit while iterating.
  assert property (@(posedge clk) disable iff (rst) (state == ST_ITER) |-> $onehot(quot_digit_i));

endmodule
`default_nettype wire
